// File: rtl/ldpc_dec_ctrl.sv
// ---------------------------------------------------------------------------
// ldpc_dec_ctrl
//
// Frame controller wrapped around an LDPC decoder core. It collects one frame
// of LLRs (R block columns of D signed data_w-bit values) from a ready/valid
// stream, kicks the core with a one-cycle reset pulse, waits for the core to
// report completion, then streams the R columns of hard decisions out.
//
// FSM: LOAD -> KICK -> RUN -> OUT -> LOAD
//
// Optional feature: define LDPC_CTRL_TIMEOUT_EN to enable a RUN-state watchdog.
// After TMO_CYC RUN cycles without a core status, the controller captures
// core_s anyway, flags out_tmo and moves to OUT. Without the macro, RUN waits
// indefinitely and out_tmo is tied low.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_last       LLR input handshake, in_last = final beat
//   in_llr   [D*data_w]             one block column of LLRs per beat
//   out_valid/out_ready/out_last    hard-decision output handshake
//   out_bits [D]                    one block column of hard decisions
//   out_conv                        current output frame converged
//   out_tmo                         current output frame ended by watchdog
//   frm_err                         1-cycle pulse: frame dropped (early in_last)
//   core_en, core_rst               core enable / active-high core reset
//   core_l   [R*D*data_w]           registered LLR frame to the core
//   core_s   [R*D], core_status[2]  core decisions and status (!=0 = done)
//   stat_ok, stat_fail [16]         saturating converged / failed frame counts
// ---------------------------------------------------------------------------
module ldpc_dec_ctrl #(
   parameter int R       = 24,
   parameter int D       = 96,
   parameter int data_w  = 6,
   parameter int TMO_CYC = 4096
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_last,
   input  logic [D*data_w-1:0]      in_llr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic [D-1:0]             out_bits,
   output logic                     out_conv,
   output logic                     out_tmo,
   output logic                     frm_err,
   output logic                     core_en,
   output logic                     core_rst,
   output logic [R*D*data_w-1:0]    core_l,
   input  logic [R*D-1:0]           core_s,
   input  logic [1:0]               core_status,
   output logic [15:0]              stat_ok,
   output logic [15:0]              stat_fail
);

   localparam int COL_W  = D * data_w;
   localparam int BEAT_W = (R > 1) ? $clog2(R) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(R - 1);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_KICK = 2'd1,
      S_RUN  = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [BEAT_W-1:0]    beat;      // input beat in LOAD, output beat in OUT
   logic [R*D-1:0]       cap_s;     // decisions captured when the core finished
   logic                 conv_q;
   logic                 load_rdy;
   logic                 core_done;
   logic                 tmo_hit;

   assign core_done = (core_status != 2'b00);

`ifdef LDPC_CTRL_TIMEOUT_EN
   localparam int RUN_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   logic [RUN_W-1:0] run_cnt;
   logic             tmo_q;

   // run_cnt counts completed RUN cycles; this is the TMO_CYC-th one.
   assign tmo_hit = (state_q == S_RUN) && !core_done &&
                    (run_cnt == RUN_W'(TMO_CYC - 1));
   assign out_tmo = tmo_q;
`else
   assign tmo_hit = 1'b0;
   assign out_tmo = 1'b0;
`endif

   assign out_conv = conv_q;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_LOAD;
      else        state_q <= state_d;
   end

   // ------------------------------------------------------------------------
   // Next state and state-decoded outputs
   // ------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      load_rdy  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_bits  = '0;
      core_en   = 1'b0;
      core_rst  = 1'b0;
      unique case (state_q)
         S_LOAD: begin
            load_rdy = 1'b1;
            if (in_valid && beat == LAST_BEAT) state_d = S_KICK;
         end
         S_KICK: begin
            // core_status is deliberately ignored while the core is reset
            core_rst = 1'b1;
            core_en  = 1'b1;
            state_d  = S_RUN;
         end
         S_RUN: begin
            core_en = 1'b1;
            if (core_done || tmo_hit) state_d = S_OUT;
         end
         S_OUT: begin
            out_valid = 1'b1;
            out_last  = (beat == LAST_BEAT);
            out_bits  = cap_s[int'(beat)*D +: D];
            if (out_ready && beat == LAST_BEAT) state_d = S_LOAD;
         end
         default: state_d = S_LOAD;
      endcase
   end

   // state_q sits in LOAD during reset, so ready is also gated by rst_n to
   // keep it low while reset is asserted.
   assign in_ready = load_rdy & rst_n;

   // ------------------------------------------------------------------------
   // Datapath: LLR frame register, beat counter, capture, statistics
   // ------------------------------------------------------------------------
   // NOTE: core_l is a wide storage array, yet it is reset here because the
   // core must see a defined all-zero frame after reset, not stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat      <= '0;
         core_l    <= '0;
         cap_s     <= '0;
         conv_q    <= 1'b0;
         frm_err   <= 1'b0;
         stat_ok   <= '0;
         stat_fail <= '0;
`ifdef LDPC_CTRL_TIMEOUT_EN
         run_cnt   <= '0;
         tmo_q     <= 1'b0;
`endif
      end else begin
         frm_err <= 1'b0;
         unique case (state_q)
            S_LOAD: begin
               if (in_valid) begin
                  core_l[int'(beat)*COL_W +: COL_W] <= in_llr;
                  if (beat == LAST_BEAT) begin
                     beat <= '0;               // in_last is don't-care here
                  end else if (in_last) begin
                     beat    <= '0;            // short frame: drop and restart
                     frm_err <= 1'b1;
                  end else begin
                     beat <= beat + BEAT_W'(1);
                  end
               end
            end
            S_KICK: begin
`ifdef LDPC_CTRL_TIMEOUT_EN
               run_cnt <= '0;
`endif
            end
            S_RUN: begin
               if (core_done) begin
                  cap_s  <= core_s;
                  conv_q <= core_status[0];
`ifdef LDPC_CTRL_TIMEOUT_EN
                  tmo_q  <= 1'b0;
`endif
                  if (core_status[0]) begin
                     if (stat_ok != 16'hFFFF) stat_ok <= stat_ok + 16'd1;
                  end else begin
                     if (stat_fail != 16'hFFFF) stat_fail <= stat_fail + 16'd1;
                  end
               end
`ifdef LDPC_CTRL_TIMEOUT_EN
               else if (tmo_hit) begin
                  cap_s  <= core_s;
                  conv_q <= 1'b0;
                  tmo_q  <= 1'b1;
                  if (stat_fail != 16'hFFFF) stat_fail <= stat_fail + 16'd1;
               end else begin
                  run_cnt <= run_cnt + RUN_W'(1);
               end
`endif
            end
            S_OUT: begin
               if (out_ready) begin
                  if (beat == LAST_BEAT) beat <= '0;
                  else                   beat <= beat + BEAT_W'(1);
               end
            end
            default: beat <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ldpc_dec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ldpc_dec_ctrl
//
// Directed bench for ldpc_dec_ctrl at default parameters. A table of frame
// vectors (core status, core latency, output back-pressure pattern, expected
// convergence flag and statistics) is run in a loop; hand-written sequences
// cover the reset state, a short frame (framing error), reset during RUN and,
// when LDPC_CTRL_TIMEOUT_EN is defined, the watchdog timeout.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_ldpc_dec_ctrl;

   localparam int R   = 24;
   localparam int D   = 96;
   localparam int W   = 6;
   localparam int COL = D * W;
   localparam int TMO = 4096;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid, in_ready, in_last;
   logic [COL-1:0]     in_llr;
   logic               out_valid, out_ready, out_last;
   logic [D-1:0]       out_bits;
   logic               out_conv, out_tmo, frm_err;
   logic               core_en, core_rst;
   logic [R*COL-1:0]   core_l;
   logic [R*D-1:0]     core_s;
   logic [1:0]         core_status;
   logic [15:0]        stat_ok, stat_fail;

   int n_chk  = 0;
   int n_fail = 0;

   logic [R*COL-1:0]   exp_l;
   logic [R*D-1:0]     s_pat;

   typedef struct {
      logic [1:0] st;        // status the core reports
      int         run_cyc;   // extra RUN cycles before the status appears
      bit         toggle;    // out_ready toggles 1/0 when set
      bit         exp_conv;
      int         exp_ok;
      int         exp_fail;
   } vec_t;

   vec_t vecs[3];

   ldpc_dec_ctrl #(.R(R), .D(D), .data_w(W), .TMO_CYC(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_last     (in_last),
      .in_llr      (in_llr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .out_bits    (out_bits),
      .out_conv    (out_conv),
      .out_tmo     (out_tmo),
      .frm_err     (frm_err),
      .core_en     (core_en),
      .core_rst    (core_rst),
      .core_l      (core_l),
      .core_s      (core_s),
      .core_status (core_status),
      .stat_ok     (stat_ok),
      .stat_fail   (stat_fail)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive nbeats LLR columns, in_last on the final one. Returns just after
   // the edge that accepts the final beat, with in_valid dropped.
   task automatic send_frame(input int nbeats);
      logic [COL-1:0] col;
      for (int k = 0; k < nbeats; k++) begin
         @(posedge clk); #1;
         for (int w = 0; w < COL / 32; w++) col[w*32 +: 32] = $urandom;
         in_valid = 1'b1;
         in_last  = (k == nbeats - 1);
         in_llr   = col;
         exp_l[k*COL +: COL] = col;
         @(negedge clk);
         check("in_ready_load", D'(in_ready), D'(1));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_frame(input logic [1:0] st, input int run_cyc, input bit toggle,
                            input bit is_tmo, input bit exp_conv,
                            input int exp_ok, input int exp_fail);
      int j;
      int cyc;
      int n;
      for (int w = 0; w < R * D / 32; w++) s_pat[w*32 +: 32] = $urandom;
      core_s = s_pat;
      send_frame(R);
      core_status = 2'b11;              // noise during KICK must be ignored
      @(negedge clk);
      check("kick_core_rst", D'(core_rst), D'(1));
      check("kick_core_en", D'(core_en), D'(1));
      check("kick_in_ready", D'(in_ready), D'(0));
      check("core_l_frame", D'(core_l == exp_l), D'(1));
      @(posedge clk); #1;
      core_status = 2'b00;
      @(negedge clk);
      check("run_core_rst", D'(core_rst), D'(0));
      check("run_core_en", D'(core_en), D'(1));
      check("run_out_valid", D'(out_valid), D'(0));
      if (!is_tmo) begin
         repeat (run_cyc) @(posedge clk);
         @(posedge clk); #1;
         core_status = st;
         @(posedge clk); #1;
         core_status = 2'b00;
         @(negedge clk);
         check("status_to_valid", D'(out_valid), D'(1));
      end else begin
         n = 1;
         while (!out_valid && n < TMO + 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
         end
         check("tmo_cycles_after_kick", D'(n), D'(TMO + 1));
      end
      check("stat_ok", D'(stat_ok), D'(exp_ok));
      check("stat_fail", D'(stat_fail), D'(exp_fail));
      check("core_en_out", D'(core_en), D'(0));
      j = 0;
      cyc = 0;
      while (j < R && cyc < 200) begin
         @(posedge clk); #1;
         out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         @(negedge clk);
         cyc++;
         check("out_valid", D'(out_valid), D'(1));
         check("out_bits", out_bits, s_pat[j*D +: D]);
         check("out_last", D'(out_last), D'(j == R - 1));
         check("out_conv", D'(out_conv), D'(exp_conv));
         check("out_tmo", D'(out_tmo), D'(is_tmo));
         if (out_ready) j++;
      end
      check("beats_delivered", D'(j), D'(R));
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("back_to_load_valid", D'(out_valid), D'(0));
      check("back_to_load_ready", D'(in_ready), D'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{st: 2'b01, run_cyc: 40, toggle: 1'b0, exp_conv: 1'b1, exp_ok: 1, exp_fail: 0};
      vecs[1] = '{st: 2'b10, run_cyc: 5,  toggle: 1'b1, exp_conv: 1'b0, exp_ok: 1, exp_fail: 1};
      vecs[2] = '{st: 2'b11, run_cyc: 0,  toggle: 1'b1, exp_conv: 1'b1, exp_ok: 2, exp_fail: 1};

      rst_n = 1'b0;
      in_valid = 1'b0; in_last = 1'b0; in_llr = '0;
      out_ready = 1'b0; core_s = '0; core_status = 2'b00;
      exp_l = '0; s_pat = '0;

      // Reset state
      #1;
      check("rst_in_ready", D'(in_ready), D'(0));
      check("rst_out_valid", D'(out_valid), D'(0));
      check("rst_core_en", D'(core_en), D'(0));
      check("rst_core_rst", D'(core_rst), D'(0));
      check("rst_stat_ok", D'(stat_ok), D'(0));
      check("rst_stat_fail", D'(stat_fail), D'(0));
      check("rst_core_l", D'(core_l == '0), D'(1));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", D'(in_ready), D'(1));

      // Short frame: in_last on beat 10
      send_frame(11);
      @(negedge clk);
      check("frm_err_pulse", D'(frm_err), D'(1));
      check("frm_err_no_kick", D'(core_rst), D'(0));
      check("frm_err_in_ready", D'(in_ready), D'(1));
      @(posedge clk); #1;
      @(negedge clk);
      check("frm_err_one_cycle", D'(frm_err), D'(0));
      check("frm_err_no_kick2", D'(core_rst), D'(0));

      // Table of full frames
      for (int i = 0; i < 3; i++)
         run_frame(vecs[i].st, vecs[i].run_cyc, vecs[i].toggle, 1'b0,
                   vecs[i].exp_conv, vecs[i].exp_ok, vecs[i].exp_fail);

      // Reset pulsed while in RUN
      send_frame(R);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrun_rst_core_en", D'(core_en), D'(0));
      check("midrun_rst_core_rst", D'(core_rst), D'(0));
      check("midrun_rst_in_ready", D'(in_ready), D'(0));
      check("midrun_rst_out_valid", D'(out_valid), D'(0));
      check("midrun_rst_stat_ok", D'(stat_ok), D'(0));
      check("midrun_rst_stat_fail", D'(stat_fail), D'(0));
      check("midrun_rst_conv", D'(out_conv), D'(0));
      check("midrun_rst_core_l", D'(core_l == '0), D'(1));
      @(posedge clk); #1;
      rst_n = 1'b1;
      core_status = 2'b01;              // stale done must not produce output
      @(negedge clk);
      check("rel_in_ready", D'(in_ready), D'(1));
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("rel_no_output", D'(out_valid), D'(0));
      end
      core_status = 2'b00;

      // Normal frame after reset; statistics restart from zero
      run_frame(2'b01, 3, 1'b0, 1'b0, 1'b1, 1, 0);

`ifdef LDPC_CTRL_TIMEOUT_EN
      run_frame(2'b00, 0, 1'b0, 1'b1, 1'b0, 1, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
